// File: rtl/result_readback_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : result_readback_unit
// Brief   : 8x8 result store with written flags; streams a slot range out
//           over a valid/ready port, one word per two cycles.
// Revision: 1.0
// ============================================================================
module result_readback_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       clear,
    input  logic       start,
    input  logic [2:0] start_addr,
    input  logic [3:0] count,
    output logic [7:0] out_data,
    output logic [2:0] out_addr,
    output logic       out_stale,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [7:0] r_mem [0:7];
    logic [7:0] r_flag;
    logic [1:0] r_state;
    logic [2:0] r_ptr;
    logic [3:0] r_remaining;
    logic [7:0] r_out_data;
    logic [2:0] r_out_addr;
    logic       r_out_stale;
    logic       r_out_last;

    logic [3:0] w_count_eff;
    logic       w_bypass;
    logic [7:0] w_flag_next;

    assign w_count_eff = (count > 4'd8) ? 4'd8 : count;
    assign w_bypass    = wr_en && (wr_addr == r_ptr);
    // A write in the same cycle as clear leaves its own flag set.
    assign w_flag_next = (clear ? 8'h00 : r_flag) | (wr_en ? (8'h01 << wr_addr) : 8'h00);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_flag <= 8'h00;
        end else begin
            if (wr_en) begin
                r_mem[wr_addr] <= wr_data;
            end
            r_flag <= w_flag_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 3'd0;
            r_remaining <= 4'd0;
            r_out_data  <= 8'h00;
            r_out_addr  <= 3'd0;
            r_out_stale <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ptr       <= start_addr;
                        r_remaining <= w_count_eff;
                        r_state     <= (w_count_eff == 4'd0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Forward a same-cycle write so the freshest product is streamed.
                    r_out_data  <= w_bypass ? wr_data : r_mem[r_ptr];
                    r_out_addr  <= r_ptr;
                    r_out_stale <= w_bypass ? 1'b0 : ~r_flag[r_ptr];
                    r_out_last  <= (r_remaining == 4'd1);
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (r_remaining == 4'd1) begin
                            r_state <= S_DONE;
                        end else begin
                            r_remaining <= r_remaining - 4'd1;
                            r_ptr       <= r_ptr + 3'd1;
                            r_state     <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are forced low for as long as reset is held, not just after its edge.
    assign out_valid = rst && (r_state == S_SEND);
    assign busy      = rst && (r_state != S_IDLE);
    assign done      = rst && (r_state == S_DONE);
    assign out_data  = {8{rst}} & r_out_data;
    assign out_addr  = {3{rst}} & r_out_addr;
    assign out_stale = rst && r_out_stale;
    assign out_last  = rst && r_out_last;

endmodule
`default_nettype wire

// File: doc/result_readback_unit.md
RESULT_READBACK_UNIT -- requirements
Module: result_readback_unit

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 8-bit data, 3-bit address and 8 entries.
REQ-002 The block SHALL run on one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; 0 on a rising clk edge resets the block.
REQ-005 wr_en  input  1  result write strobe from the multiplier stage.
REQ-006 wr_addr  input  3  result slot to write.
REQ-007 wr_data  input  8  product to store.
REQ-008 clear  input  1  invalidates all slots (written flags only).
REQ-009 start  input  1  single-cycle readback command.
REQ-010 start_addr  input  3  first slot to read.
REQ-011 count  input  4  number of slots to read; legal range 0..8.
REQ-012 out_data  output  8  streamed result.
REQ-013 out_addr  output  3  slot index of out_data.
REQ-014 out_stale  output  1  high when the streamed slot was never written since the last reset or clear.
REQ-015 out_valid  output  1  out_* fields hold a word.
REQ-016 out_ready  input  1  consumer accepts the word.
REQ-017 out_last  output  1  marks the final word of a command.
REQ-018 busy  output  1  high whenever the FSM is not in IDLE.
REQ-019 done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-020 Storage SHALL be an 8x8 register array plus an 8-bit written-flag vector.
REQ-021 A write with wr_en=1 SHALL update mem[wr_addr] and set flag[wr_addr] on the clock edge, in any FSM state.
REQ-022 clear=1 SHALL zero all flags on the clock edge without altering mem.
- If clear=1 and wr_en=1 occur in the same cycle, the flag for wr_addr ends set.
REQ-023 The FSM SHALL have four states: IDLE, FETCH, SEND, DONE.
REQ-024 In IDLE, start=1 with count in 1..8 SHALL do the following, then move to FETCH on the next edge:
- latch ptr=start_addr;
- latch remaining=count.
REQ-025 In IDLE, start=1 with count=0 SHALL skip FETCH/SEND and go directly to DONE.
REQ-026 A count value of 9..15 SHALL be treated as 8.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 FETCH SHALL last one cycle and register the following, then move to SEND:
- out_data=mem[ptr];
- out_addr=ptr;
- out_stale=~flag[ptr];
- out_last=(remaining==1).
REQ-029 If wr_en=1 and wr_addr==ptr in the FETCH cycle, FETCH SHALL bypass the array: out_data=wr_data and out_stale=0.
REQ-030 In SEND, out_valid SHALL be 1 and all out_* fields SHALL be held stable until out_ready=1.
REQ-031 A SEND cycle with out_ready=1 is a handshake and SHALL do the following:
- if remaining==1, go to DONE;
- otherwise decrement remaining, set ptr=ptr+1 modulo 8 (7 wraps to 0), and go to FETCH.
REQ-032 Word rate SHALL be one word per two cycles; first out_valid SHALL appear 2 cycles after the start edge.
REQ-033 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-034 out_valid SHALL be 0 in IDLE, FETCH and DONE.
REQ-035 A write to a slot after that slot's FETCH SHALL NOT alter the word already presented.
REQ-036 clear during a command SHALL NOT alter the word already presented; it affects only later FETCHes.

Reset
REQ-037 rst=0 SHALL do all of the following on the clock edge, regardless of state:
- force IDLE;
- clear all mem entries to 0x00;
- clear all flags;
- clear ptr and remaining.
REQ-038 While rst=0, out_data, out_addr, out_stale, out_valid, out_last, busy and done SHALL all be 0.
REQ-039 While rst=0, wr_en, clear and start SHALL be ignored.
REQ-040 Reset asserted mid-command SHALL abort the command with no done pulse.

Verification
REQ-041 Basic readback:
- stimulus: write 0x0F@2 and 0x31@3, then start_addr=2, count=2, out_ready=1;
- response: words (2,0x0F,stale0,last0) then (3,0x31,stale0,last1); done pulse 1 cycle after the second handshake.
REQ-042 Wrap and stale:
- stimulus: write only slot 7=0xE1, then start_addr=7, count=2;
- response: (7,0xE1,stale0), then (0,0x00,stale1,last1).
REQ-043 Backpressure:
- stimulus: out_ready=0 for 5 cycles during SEND, with a write to that slot meanwhile;
- response: out_valid held and out_data/out_addr unchanged; the word is accepted on the first out_ready=1 cycle.
REQ-044 Edge counts and busy:
- count=0: done pulse 1 cycle after start, out_valid never asserted;
- count=12: exactly 8 words, slots start_addr..start_addr+7 mod 8;
- second start while busy: ignored.
REQ-045 Same-cycle write bypass:
- stimulus: wr_en with wr_addr=ptr and wr_data=0x24 in the FETCH cycle;
- response: presented word is 0x24 with stale0.
REQ-046 Reset mid-stream:
- stimulus: rst=0 during SEND;
- response: next cycle out_valid=0, busy=0, no done pulse; a new count=1 read after reset returns 0x00 with stale1.
